// File: rtl/idct16_serial_if.sv
// idct16_serial_if: stream bundle for the serial 16-point IDCT.
//   s_* : coefficient input stream (X[0..15] per frame), valid/ready
//   m_* : sample output stream (x[0..15] per frame), valid/ready
// Modports:
//   slave  - the IDCT block (consumes s_*, produces m_*)
//   master - the environment (produces s_*, consumes m_*)
interface idct16_serial_if #(
    parameter int DATA_W = 20
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/idct16_serial.sv
// idct16_serial: 16-point orthonormal inverse DCT (DCT-III), serial in/out.
// One frame of 16 coefficients is loaded, then each output sample is
// produced by a 16-step multiply-accumulate against a constant weight ROM.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   bus        idct16_serial_if.slave (s_* coefficient stream in, m_* sample stream out)
//   busy       high whenever the block is not accepting input
//   frame_err  sticky: s_last seen on a beat other than the 16th, or missing on it
module idct16_serial #(
    parameter int DATA_W = 20,
    parameter int COEF_W = 16,
    parameter int FRAC   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    idct16_serial_if.slave        bus,
    output logic                  busy,
    output logic                  frame_err
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + 4;     // headroom for 16 accumulated products

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1 <<< (FRAC-1));

    typedef enum logic [2:0] {
        S_LOAD, S_COMPUTE, S_DRAIN, S_ROUND, S_OUT
    } state_t;

    state_t                    r_state, w_next;
    logic [3:0]                r_kcnt;
    logic [3:0]                r_n;
    logic signed [DATA_W-1:0]  r_buf [16];
    logic signed [PROD_W-1:0]  r_prod;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]         r_mdata;
    logic                      r_mvalid;
    logic                      r_mlast;
    logic                      r_ferr;

    logic                      w_sready;
    logic                      w_busy;
    logic                      w_shs;
    logic                      w_mhs;
    logic signed [COEF_W-1:0]  w_coef;
    logic signed [PROD_W-1:0]  w_a, w_b, w_prod;
    logic signed [ACC_W-1:0]   w_rnd;
    logic [DATA_W-1:0]         w_sat;

    // W[n][k] = round(2^15 * sqrt(1/8) * a_k * cos((2n+1)k*pi/32)).
    // The cosine argument is folded modulo 2*pi into a quarter-wave table
    // of 17 magnitudes plus a sign.
    function automatic logic signed [COEF_W-1:0] rom(input logic [3:0] n, input logic [3:0] k);
        logic [5:0]               m;
        logic [4:0]               j;
        logic                     neg;
        logic signed [COEF_W-1:0] mag;
        m = 6'({1'b0, n, 1'b1} * {2'b00, k});   // (2n+1)k mod 64
        if (m <= 6'd16) begin
            j = m[4:0];             neg = 1'b0;
        end else if (m <= 6'd32) begin
            j = 5'(6'd32 - m);      neg = 1'b1;
        end else if (m <= 6'd48) begin
            j = 5'(m - 6'd32);      neg = 1'b1;
        end else begin
            j = 5'(7'd64 - {1'b0, m}); neg = 1'b0;
        end
        case (j)
            5'd0:    mag = COEF_W'(11585);
            5'd1:    mag = COEF_W'(11529);
            5'd2:    mag = COEF_W'(11363);
            5'd3:    mag = COEF_W'(11086);
            5'd4:    mag = COEF_W'(10703);
            5'd5:    mag = COEF_W'(10217);
            5'd6:    mag = COEF_W'(9633);
            5'd7:    mag = COEF_W'(8956);
            5'd8:    mag = COEF_W'(8192);
            5'd9:    mag = COEF_W'(7350);
            5'd10:   mag = COEF_W'(6436);
            5'd11:   mag = COEF_W'(5461);
            5'd12:   mag = COEF_W'(4433);
            5'd13:   mag = COEF_W'(3363);
            5'd14:   mag = COEF_W'(2260);
            5'd15:   mag = COEF_W'(1136);
            default: mag = '0;
        endcase
        if (k == 4'd0)
            rom = COEF_W'(8192);    // DC column carries the extra 1/sqrt(2)
        else
            rom = neg ? -mag : mag;
    endfunction

    assign w_coef = rom(r_n, r_kcnt);
    assign w_a    = PROD_W'(r_buf[r_kcnt]);
    assign w_b    = PROD_W'(w_coef);
    assign w_prod = w_a * w_b;

    assign w_rnd  = (r_acc + RND) >>> FRAC;
    assign w_sat  = (w_rnd > SAT_HI) ? SAT_HI[DATA_W-1:0] :
                    (w_rnd < SAT_LO) ? SAT_LO[DATA_W-1:0] : w_rnd[DATA_W-1:0];

    assign w_shs  = bus.s_valid && w_sready;
    assign w_mhs  = r_mvalid && bus.m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_sready = 1'b0;
        w_busy   = 1'b1;
        case (r_state)
            S_LOAD: begin
                w_sready = 1'b1;
                w_busy   = 1'b0;
                if (bus.s_valid && r_kcnt == 4'd15) w_next = S_COMPUTE;
            end
            S_COMPUTE: if (r_kcnt == 4'd15) w_next = S_DRAIN;
            S_DRAIN:   w_next = S_ROUND;
            S_ROUND:   w_next = S_OUT;
            S_OUT:     if (w_mhs) w_next = (r_n == 4'd15) ? S_LOAD : S_COMPUTE;
            default:   w_next = S_LOAD;
        endcase
    end

    // Coefficient buffer is fully rewritten before every use; no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && w_shs) r_buf[r_kcnt] <= bus.s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kcnt   <= '0;
            r_n      <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_mdata  <= '0;
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: if (w_shs) begin
                    if (bus.s_last != (r_kcnt == 4'd15)) r_ferr <= 1'b1;
                    if (r_kcnt == 4'd15) r_n <= '0;
                    r_kcnt <= r_kcnt + 4'd1;
                end
                S_COMPUTE: begin
                    // Product k is registered here and summed one cycle later;
                    // the product of k=0 replaces whatever the accumulator held.
                    r_prod <= w_prod;
                    if (r_kcnt == 4'd1)      r_acc <= ACC_W'(r_prod);
                    else if (r_kcnt != 4'd0) r_acc <= r_acc + ACC_W'(r_prod);
                    r_kcnt <= r_kcnt + 4'd1;
                end
                S_DRAIN: r_acc <= r_acc + ACC_W'(r_prod);
                S_ROUND: begin
                    r_mdata  <= w_sat;
                    r_mlast  <= (r_n == 4'd15);
                    r_mvalid <= 1'b1;
                end
                S_OUT: if (w_mhs) begin
                    r_mvalid <= 1'b0;
                    if (r_n != 4'd15) r_n <= r_n + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready = w_sready;
    assign bus.m_data  = r_mdata;
    assign bus.m_valid = r_mvalid;
    assign bus.m_last  = r_mlast;
    assign busy        = w_busy;
    assign frame_err   = r_ferr;
endmodule

// File: tb/tb_idct16_serial.sv
// tb_idct16_serial: randomized self-checking bench for idct16_serial.
// Expected samples come from a real-arithmetic IDCT model (weights built
// with $cos), queued per frame and checked on every output handshake.
module tb_idct16_serial;
    logic clk = 1'b0;
    logic rst;
    logic busy, frame_err;

    idct16_serial_if #(.DATA_W(20)) bus ();

    idct16_serial #(.DATA_W(20), .COEF_W(16), .FRAC(15)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { longint data; bit last; } exp_t;

    int     tests = 0, fails = 0;
    int     cyc = 0;
    int     W [16][16];
    int     fx [16];
    longint fy [16];
    longint got [16];
    exp_t   expq [$];
    bit     mon_en = 0, mr_rand = 0;
    int     in_cnt = 0, out_cnt = 0, oidx = 0, t_acc = 0;
    bit     armed = 0, pv = 0, pr = 0, pl = 0;
    longint pd = 0;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void build_rom();
        real r;
        for (int n = 0; n < 16; n++)
            for (int k = 0; k < 16; k++) begin
                r = 32768.0 * $sqrt(1.0/8.0) * ((k == 0) ? $sqrt(0.5) : 1.0)
                    * $cos((2*n+1) * k * 3.14159265358979 / 32.0);
                W[n][k] = (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
            end
    endfunction

    function automatic void run_model();
        longint acc;
        for (int n = 0; n < 16; n++) begin
            acc = 0;
            for (int k = 0; k < 16; k++) acc += longint'(fx[k]) * longint'(W[n][k]);
            acc = (acc + 16384) >>> 15;
            if (acc > 524287) acc = 524287;
            if (acc < -524288) acc = -524288;
            fy[n] = acc;
        end
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = mr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Compare process: outputs vs queued model, stall stability, latency.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (pv && !pr) begin
                chk("stall_valid", longint'(bus.m_valid), 1);
                chk("stall_data", longint'($signed(bus.m_data)), pd);
                chk("stall_last", longint'(bus.m_last), longint'(pl));
            end
            if (busy && bus.s_ready) begin
                tests++; fails++;
                $display("FAIL s_ready_busy: got s_ready=1, expected 0 while busy");
            end
            if (bus.m_valid && !pv) begin
                if (armed) chk("latency", cyc - t_acc, 18);
                armed = 0;
            end
            if (bus.s_valid && bus.s_ready) begin
                in_cnt++;
                if (in_cnt == 16) begin in_cnt = 0; t_acc = cyc + 1; armed = 1; end
            end
            if (bus.m_valid && bus.m_ready) begin
                if (expq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: got %0d, expected no output", $signed(bus.m_data));
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("m_data", longint'($signed(bus.m_data)), e.data);
                    chk("m_last", longint'(bus.m_last), longint'(e.last));
                end
                got[oidx] = longint'($signed(bus.m_data));
                oidx = bus.m_last ? 0 : oidx + 1;
                out_cnt++;
                if (!bus.m_last) begin t_acc = cyc + 1; armed = 1; end
            end
            pv = bus.m_valid; pr = bus.m_ready;
            pd = longint'($signed(bus.m_data)); pl = bus.m_last;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit gaps, input int bad_beat);
        int t;
        run_model();
        for (int n = 0; n < 16; n++) expq.push_back('{fy[n], n == 15});
        for (int k = 0; k < 16; k++) begin
            if (gaps) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
            bus.s_valid = 1'b1;
            bus.s_data  = 20'(fx[k]);
            bus.s_last  = (k == 15) || (k == bad_beat);
            t = 0;
            while (!bus.s_ready && t < 5000) begin step(); t++; end
            if (t >= 5000) begin
                tests++; fails++;
                $display("FAIL s_ready_timeout: got no s_ready, expected s_ready within 5000 cycles");
            end
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((expq.size() != 0 || busy) && t < 20000) begin step(); t++; end
        if (t >= 20000) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", expq.size());
        end
    endtask

    task automatic fill_const(input int v0, input int vrest);
        for (int k = 0; k < 16; k++) fx[k] = (k == 0) ? v0 : vrest;
    endtask

    task automatic fill_rand(input int range);
        for (int k = 0; k < 16; k++)
            fx[k] = int'($urandom_range(0, 2*range - 1)) - range;
    endtask

    task automatic reset_mon();
        in_cnt = 0; out_cnt = 0; oidx = 0; armed = 0;
        pv = 0; pr = 0; pl = 0; pd = 0;
        expq.delete();
    endtask

    initial begin
        int t;
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        build_rom();
        repeat (3) step();
        chk("rst_s_ready", longint'(bus.s_ready), 1);
        chk("rst_m_valid", longint'(bus.m_valid), 0);
        chk("rst_m_last", longint'(bus.m_last), 0);
        chk("rst_m_data", longint'(bus.m_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_frame_err", longint'(frame_err), 0);
        rst = 1'b1;
        mon_en = 1'b1;
        step();

        // Hand-computed pins on the model itself.
        fill_const(1000, 0);   run_model();
        chk("model_dc0", fy[0], 250);
        chk("model_dc15", fy[15], 250);
        fill_const(0, 0); fx[1] = 32768; run_model();
        chk("model_ac0", fy[0], 11529);
        chk("model_ac1", fy[1], 11086);
        chk("model_ac15", fy[15], -11529);

        // DC frame, no gaps, m_ready high.
        fill_const(1000, 0);
        send_frame(0, -1); wait_drain();
        chk("dc_x0", got[0], 250);
        chk("dc_x15", got[15], 250);
        chk("dc_frame_err", longint'(frame_err), 0);

        // Single AC coefficient.
        fill_const(0, 0); fx[1] = 32768;
        send_frame(1, -1); wait_drain();
        chk("ac_x0", got[0], 11529);
        chk("ac_x15", got[15], -11529);

        // Saturation both ways.
        fill_const(524287, 524287);
        send_frame(0, -1); wait_drain();
        chk("sat_pos_x0", got[0], 524287);
        fill_const(-524287, -524287);
        send_frame(0, -1); wait_drain();
        chk("sat_neg_x0", got[0], -524288);

        // Random data with output backpressure and input gaps.
        mr_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            fill_rand((f % 2 == 0) ? 4096 : 524288);
            send_frame(1, -1); wait_drain();
        end
        chk("rand_frame_err", longint'(frame_err), 0);

        // Framing error on beat 7: still a 16-beat frame.
        fill_rand(100000);
        send_frame(1, 7); wait_drain();
        chk("ferr_set", longint'(frame_err), 1);
        fill_rand(100000);
        send_frame(1, -1); wait_drain();
        chk("ferr_sticky", longint'(frame_err), 1);

        // Reset in the middle of computing x[5].
        mr_rand = 1'b0;
        step();
        out_cnt = 0;
        fill_rand(50000);
        send_frame(0, -1);
        t = 0;
        while (out_cnt < 5 && t < 5000) begin step(); t++; end
        if (t >= 5000) begin
            tests++; fails++;
            $display("FAIL mid_wait: got %0d outputs, expected 5", out_cnt);
        end
        repeat (4) step();
        chk("mid_busy", longint'(busy), 1);
        chk("mid_ferr", longint'(frame_err), 1);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_m_valid", longint'(bus.m_valid), 0);
        chk("mid_rst_m_data", longint'(bus.m_data), 0);
        chk("mid_rst_m_last", longint'(bus.m_last), 0);
        chk("mid_rst_s_ready", longint'(bus.s_ready), 1);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_ferr", longint'(frame_err), 0);
        reset_mon();
        repeat (3) step();
        rst = 1'b1;
        mon_en = 1'b1;
        step();

        fill_const(1000, 0);
        send_frame(0, -1); wait_drain();
        for (int n = 0; n < 16; n++) chk("post_rst_dc", got[n], 250);
        chk("post_rst_ferr", longint'(frame_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
